clz_clo_decode: RTL and testbench

- Inverse of the leading-zero/leading-one counter: takes a normalized word plus a leading-zero count and rebuilds the denormalized word.
- Output is the input word logically right-shifted by the count, so a CLZ of the result returns the same count.
- Sits on the renormalization/unpack side of datapaths that store words as {count, normalized word}.
- Iterative: one binary shift stage per clock, valid/ready handshake on both sides.

---
 rtl/clz_clo_decode_if.sv | 40 ++++
 rtl/clz_clo_decode.sv | 108 ++++++++++
 tb/tb_clz_clo_decode.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/clz_clo_decode_if.sv
// Request/result handshake bundle for clz_clo_decode.
// in_mode exists only when CLZ_CLO_DECODE_CLO_EN is defined.
interface clz_clo_decode_if #(
  parameter int unsigned WI_SZ = 32,
  parameter int unsigned WO_SZ = $clog2(WI_SZ) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WO_SZ-1:0] in_cnt;
  logic [WI_SZ-1:0] in_norm;
`ifdef CLZ_CLO_DECODE_CLO_EN
  logic             in_mode;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WI_SZ-1:0] out_word;
  logic             out_err;

`ifdef CLZ_CLO_DECODE_CLO_EN
  modport master (
    output in_valid, in_cnt, in_norm, in_mode, out_ready,
    input  in_ready, out_valid, out_word, out_err
  );

  modport slave (
    input  in_valid, in_cnt, in_norm, in_mode, out_ready,
    output in_ready, out_valid, out_word, out_err
  );
`else
  modport master (
    output in_valid, in_cnt, in_norm, out_ready,
    input  in_ready, out_valid, out_word, out_err
  );

  modport slave (
    input  in_valid, in_cnt, in_norm, out_ready,
    output in_ready, out_valid, out_word, out_err
  );
`endif
endinterface

// File: rtl/clz_clo_decode.sv
// Iterative denormalizer: out_word = in_norm >> min(in_cnt, WI_SZ), one binary stage per clock.
// Optional CLZ_CLO_DECODE_CLO_EN adds in_mode to select ones-fill (leading-ones restore).
module clz_clo_decode #(
  parameter int unsigned WI_SZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  clz_clo_decode_if.slave bus
);
  localparam int unsigned WO_SZ = $clog2(WI_SZ) + 1;
  localparam int unsigned STG_W = $clog2(WO_SZ);
  localparam logic [WI_SZ-1:0] ONES     = '1;
  localparam logic [WO_SZ-1:0] CNT_MAX  = WO_SZ'(WI_SZ);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(WO_SZ - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WI_SZ-1:0] work;
  logic [WO_SZ-1:0] cnt;
  logic [STG_W-1:0] stage;
  logic             err;
  logic             fill;
  logic [WI_SZ-1:0] shift_c;

`ifdef CLZ_CLO_DECODE_CLO_EN
  // Fill bit is captured with the request like every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      fill <= bus.in_mode;
    end
  end
`else
  assign fill = 1'b0;
`endif

  // Stage k applies a 2^k shift when count bit k is set; shifts >= WI_SZ leave pure fill.
  always_comb begin
    shift_c = work;
    for (int k = 0; k < int'(WO_SZ); k++) begin
      if (stage == STG_W'(k) && cnt[k]) begin
        if ((1 << k) >= int'(WI_SZ)) begin
          shift_c = {WI_SZ{fill}};
        end else begin
          shift_c = (work >> (1 << k)) | ({WI_SZ{fill}} & ~(ONES >> (1 << k)));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_word  <= '0;
      bus.out_err   <= 1'b0;
      work          <= '0;
      cnt           <= '0;
      stage         <= '0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work <= bus.in_norm;
            if (bus.in_cnt > CNT_MAX) begin
              cnt <= CNT_MAX;
              err <= 1'b1;
            end else begin
              cnt <= bus.in_cnt;
              err <= 1'b0;
            end
            stage        <= '0;
            state        <= SHIFT;
            bus.in_ready <= 1'b0;
          end
        end
        // Fixed WO_SZ stages regardless of count value.
        SHIFT: begin
          work  <= shift_c;
          stage <= stage + STG_W'(1);
          if (stage == STG_LAST) begin
            stage         <= '0;
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_word  <= shift_c;
            bus.out_err   <= err;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clz_clo_decode.sv
// Randomized self-checking bench for clz_clo_decode against a wide-shift reference model.
module tb_clz_clo_decode;
  localparam int unsigned WI = 32;
  localparam int unsigned WO = 6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  clz_clo_decode_if #(.WI_SZ(WI), .WO_SZ(WO)) bus ();

  clz_clo_decode #(.WI_SZ(WI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Place the fill pattern above the word and shift the 64-bit value.
  function automatic logic [31:0] ref_decode(input logic [31:0] norm, input int cnt, input bit mode);
    logic [63:0] wide;
    int sh;
    sh   = (cnt > 32) ? 32 : cnt;
    wide = mode ? {32'hFFFF_FFFF, norm} : {32'h0000_0000, norm};
    return 32'(wide >> sh);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int cnt, input logic [31:0] norm, input bit mode);
    bus.in_valid = 1'b1;
    bus.in_cnt   = WO'(cnt);
    bus.in_norm  = norm;
`ifdef CLZ_CLO_DECODE_CLO_EN
    bus.in_mode  = mode;
`else
    if (mode) bus.in_valid = 1'b1;
`endif
  endtask

  task automatic run_txn(input int cnt, input logic [31:0] norm, input bit mode, input int hold);
    logic [31:0] exp_word;
    logic [31:0] held;
    bit          eff_mode;
    int          lat;
`ifdef CLZ_CLO_DECODE_CLO_EN
    eff_mode = mode;
`else
    eff_mode = 1'b0;
`endif
    exp_word = ref_decode(norm, cnt, eff_mode);
    check("ready_idle", 64'(bus.in_ready), 64'(1));
    drive_req(cnt, norm, mode);
    bus.out_ready = 1'b0;
    tick();
    // Inputs change after accept and in_valid stays high: must have no effect.
    bus.in_valid = 1'b1;
    bus.in_cnt   = WO'($urandom);
    bus.in_norm  = $urandom;
`ifdef CLZ_CLO_DECODE_CLO_EN
    bus.in_mode  = ~mode;
`endif
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check("ready_busy", 64'(bus.in_ready), 64'(0));
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(WO));
    check("out_word", 64'(bus.out_word), 64'(exp_word));
    check("out_err", 64'(bus.out_err), 64'(cnt > 32));
    held = bus.out_word;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(bus.out_valid), 64'(1));
      check("hold_word", 64'(bus.out_word), 64'(held));
      check("hold_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("post_valid", 64'(bus.out_valid), 64'(0));
    check("post_ready", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    int          rc;
    logic [31:0] rn;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_cnt    = '0;
    bus.in_norm   = '0;
    bus.out_ready = 1'b0;
`ifdef CLZ_CLO_DECODE_CLO_EN
    bus.in_mode   = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 64'(bus.in_ready), 64'(1));
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_word", 64'(bus.out_word), 64'(0));
    check("rst_err", 64'(bus.out_err), 64'(0));

    run_txn(0,  32'h8000_0001, 1'b0, 0);
    run_txn(5,  32'hF000_0000, 1'b0, 3);
    run_txn(31, 32'h8000_0000, 1'b0, 0);
    run_txn(32, 32'hFFFF_FFFF, 1'b0, 0);
    run_txn(40, 32'hFFFF_FFFF, 1'b0, 1);
    run_txn(63, 32'h1234_5678, 1'b0, 0);

    // Reset while in SHIFT stage 2 drops the operation.
    drive_req(7, 32'hDEAD_BEEF, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 64'(bus.in_ready), 64'(1));
    check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_word", 64'(bus.out_word), 64'(0));
    tick();
    check("mid_rst_quiet", 64'(bus.out_valid), 64'(0));
    run_txn(5, 32'hF000_0000, 1'b0, 0);

`ifdef CLZ_CLO_DECODE_CLO_EN
    run_txn(4, 32'h0000_0000, 1'b1, 0);
    run_txn(4, 32'h0000_0000, 1'b0, 0);
    run_txn(40, 32'h0000_0000, 1'b1, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      rc = int'($urandom_range(0, 63));
      rn = $urandom;
      if (n % 5 == 0) rn = rn >> $urandom_range(0, 31);
      run_txn(rc, rn, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
